cdc_fifo_push_arbiter: RTL and testbench
========================================

Name: cdc_fifo_push_arbiter

Overview:
- Shares the A-domain push port of one CDC FIFO between NumReq requesters, all in clock domain A.
- Grants the port to one requester at a time using round-robin arbitration.
- Each grant is a burst. It ends on the requester's Last flag, on MaxBurst words, or when the requester drops its request.
- Sits directly in front of the FIFO. It drives the FIFO's push and data inputs and consumes the FIFO's full flag.

Parameters:
- NumReq, 4, number of requesters (2..16).
- DataWidth, 32, word width. Matches the FIFO DataWidth.
- MaxBurst, 8, maximum words per grant (1..256). The burst counter width is $clog2(MaxBurst+1).

Ports:
- clk_DA  in  1  domain-A clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Req_DA  in  NumReq  per-requester request; a requester holds it while its word is presented.
- Data_DA  in  NumReq*DataWidth  requester i's word is at bits [i*DataWidth +: DataWidth].
- Last_DA  in  NumReq  marks the presented word as the final word of the requester's packet.
- Ack_DA  out  NumReq  one-hot; high in the cycle the granted requester's word is pushed.
- Grant_DA  out  NumReq  one-hot registered grant; all zero when idle.
- Push_DA  out  1  to FIFO push.
- DataIn_DA  out  DataWidth  to FIFO data input.
- FifoFull_DA  in  1  from FIFO full flag.
- Busy_DA  out  1  high while in state BURST.

Behaviour:
- Single clock, clk_DA. Reset is asynchronous and active-low (rst_n).

States:
- IDLE: Grant_DA = 0 and Push_DA = 0.
  - If any Req_DA bit is set, pick the winner by searching upward from (LastGrant+1) mod NumReq, wrapping round.
  - On the next edge: register the one-hot grant, clear BurstCnt, move to BURST.
  - Arbitration costs exactly 1 cycle, so there is always one idle cycle between bursts.
- BURST, with g the granted index:
  - Accept = Req_DA[g] & !FifoFull_DA.
  - Push_DA = Accept, Ack_DA[g] = Accept, DataIn_DA = Data_DA slice g. These are combinational from the registered grant and the inputs.
  - Ack_DA bits other than g are 0.
  - On an Accept edge, BurstCnt increments.
- Burst end, any one of:
  - Accept with Last_DA[g] = 1;
  - Accept with BurstCnt == MaxBurst-1, i.e. the MaxBurst-th word;
  - Req_DA[g] = 0 at an edge.
  - On ending: go to IDLE, set LastGrant <= g, clear Grant_DA.

Boundary conditions:
- FifoFull_DA high during BURST: no push and no ack. The grant is held indefinitely and BurstCnt is unchanged.
- Other requesters' Req_DA bits are ignored until IDLE.
- Req_DA rising in the same cycle the burst ends: it is not seen until IDLE, then arbitrated normally.
- Only one requester active: it is re-granted after each 1-cycle IDLE gap.
- Last_DA is ignored unless Accept is high.
- MaxBurst = 1: every grant is a single word.
- DataIn_DA when Push_DA = 0: don't-care, but driven as slice g (slice 0 in IDLE). It must never be X after reset.

Reset:
- State IDLE, Grant_DA = 0, BurstCnt = 0, LastGrant = NumReq-1 (so requester 0 has priority first).
- Push_DA, Ack_DA and Busy_DA are 0.
- Assertion mid-burst drops Push_DA and Ack_DA asynchronously. Words already pushed stay in the FIFO; the FIFO is reset separately.

Invariants (bench assertions):
- Push_DA implies exactly one Ack_DA bit is set, and it equals Grant_DA.
- Push_DA is never high while FifoFull_DA is high.
- Grant_DA is one-hot or zero.
- No more than MaxBurst pushes per grant.

Test Plan:
- Reset, then Req_DA=4'b0101, Last tied 0, FIFO never full, MaxBurst=8.
  - Required: grant 0 at cycle 1, 8 pushes in cycles 1-8, IDLE in cycle 9, grant 2 from cycle 10.
- Req_DA=4'b1111 held, Last_DA=4'b1111: grants go 0,1,2,3,0, one word each, with pushes every other cycle.
- Granted requester 1 with FifoFull_DA high for 5 cycles in mid-burst:
  - Required: Push_DA=0 and Ack_DA=0 for those 5 cycles, grant held, BurstCnt frozen.
  - After full clears, pushes resume and the total is exactly 8.
- Requester 3 granted, drops Req_DA[3] after 2 accepted words: IDLE next cycle, LastGrant=3, next winner is 0 if requesting.
- rst_n low during the 3rd word of a burst:
  - Required: Push_DA falls without waiting for a clock edge, Grant_DA=0.
  - After release, with all requesting, the first grant goes to requester 0.
- Data integrity: each requester sends a 5-word packet (Last on word 5) tagged {index, seq}.
  - Required: FIFO output shows contiguous, in-order 5-word packets per requester with no interleaving.

Source files
------------

// File: rtl/cdc_fifo_push_arbiter.sv
// Round-robin arbiter that shares the domain-A push port of one CDC FIFO
// between NumReq requesters. Each grant is a burst that ends on Last, on
// MaxBurst accepted words, or when the granted requester withdraws.
module cdc_fifo_push_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MaxBurst  = 8
) (
    input  logic                          clk_DA,
    input  logic                          rst_n,
    input  logic [NumReq-1:0]             Req_DA,
    input  logic [NumReq*DataWidth-1:0]   Data_DA,
    input  logic [NumReq-1:0]             Last_DA,
    output logic [NumReq-1:0]             Ack_DA,
    output logic [NumReq-1:0]             Grant_DA,
    output logic                          Push_DA,
    output logic [DataWidth-1:0]          DataIn_DA,
    input  logic                          FifoFull_DA,
    output logic                          Busy_DA
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(MaxBurst + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } stateT;

    stateT                 state, stateNxt;
    logic [IdxW-1:0]       grantIdx, grantIdxNxt;
    logic [IdxW-1:0]       lastGrant, lastGrantNxt;
    logic [NumReq-1:0]     grantNxt;
    logic [CntW-1:0]       burstCnt, burstCntNxt;
    logic                  busyNxt;

    logic                  winnerFound;
    logic [IdxW-1:0]       winnerIdx;
    logic [IdxW:0]         candIdx;
    logic                  reqG;
    logic                  accept;
    logic                  endBurst;
    logic [DataWidth-1:0]  dataSlice [NumReq];

    // Unpack the requester words so the granted one can be selected by index.
    for (genvar i = 0; i < NumReq; i++) begin : gSlice
        assign dataSlice[i] = Data_DA[i*DataWidth +: DataWidth];
    end

    // Round-robin search upward from the requester after the last winner.
    always_comb begin
        winnerFound = 1'b0;
        winnerIdx   = '0;
        candIdx     = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            candIdx = {1'b0, lastGrant} + (IdxW+1)'(k);
            if (candIdx >= (IdxW+1)'(NumReq)) begin
                candIdx = candIdx - (IdxW+1)'(NumReq);
            end
            if (!winnerFound && Req_DA[candIdx[IdxW-1:0]]) begin
                winnerFound = 1'b1;
                winnerIdx   = candIdx[IdxW-1:0];
            end
        end
    end

    // Push handshake for the granted requester; inactive outside BURST.
    always_comb begin
        reqG      = Req_DA[grantIdx];
        accept    = (state == BURST) && reqG && !FifoFull_DA;
        endBurst  = (state == BURST) &&
                    (!reqG || (accept && (Last_DA[grantIdx] ||
                                          burstCnt == CntW'(MaxBurst - 1))));
        Push_DA   = accept;
        Ack_DA    = accept ? Grant_DA : '0;
        DataIn_DA = dataSlice[grantIdx];
    end

    // Next-state logic: arbitrate in IDLE, count and terminate bursts in BURST.
    always_comb begin
        stateNxt     = state;
        grantIdxNxt  = grantIdx;
        lastGrantNxt = lastGrant;
        grantNxt     = Grant_DA;
        burstCntNxt  = burstCnt;
        busyNxt      = Busy_DA;
        case (state)
            IDLE: begin
                if (winnerFound) begin
                    stateNxt    = BURST;
                    busyNxt     = 1'b1;
                    grantIdxNxt = winnerIdx;
                    grantNxt    = NumReq'(1) << winnerIdx;
                    burstCntNxt = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    burstCntNxt = burstCnt + CntW'(1);
                end
                if (endBurst) begin
                    stateNxt     = IDLE;
                    busyNxt      = 1'b0;
                    lastGrantNxt = grantIdx;
                    grantIdxNxt  = '0;
                    grantNxt     = '0;
                end
            end
            default: begin
                stateNxt = IDLE;
                busyNxt  = 1'b0;
                grantNxt = '0;
            end
        endcase
    end

    // State register; requester 0 has first priority out of reset.
    always_ff @(posedge clk_DA or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grantIdx  <= '0;
            lastGrant <= IdxW'(NumReq - 1);
            Grant_DA  <= '0;
            burstCnt  <= '0;
            Busy_DA   <= 1'b0;
        end else begin
            state     <= stateNxt;
            grantIdx  <= grantIdxNxt;
            lastGrant <= lastGrantNxt;
            Grant_DA  <= grantNxt;
            burstCnt  <= burstCntNxt;
            Busy_DA   <= busyNxt;
        end
    end

endmodule

// File: tb/tb_cdc_fifo_push_arbiter.sv
// Directed bench for cdc_fifo_push_arbiter with a push scoreboard.
module tb_cdc_fifo_push_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 8;

    logic              clk_DA;
    logic              rst_n;
    logic [NR-1:0]     Req_DA;
    logic [NR*DW-1:0]  Data_DA;
    logic [NR-1:0]     Last_DA;
    logic [NR-1:0]     Ack_DA;
    logic [NR-1:0]     Grant_DA;
    logic              Push_DA;
    logic [DW-1:0]     DataIn_DA;
    logic              FifoFull_DA;
    logic              Busy_DA;

    cdc_fifo_push_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut (
        .clk_DA      (clk_DA),
        .rst_n       (rst_n),
        .Req_DA      (Req_DA),
        .Data_DA     (Data_DA),
        .Last_DA     (Last_DA),
        .Ack_DA      (Ack_DA),
        .Grant_DA    (Grant_DA),
        .Push_DA     (Push_DA),
        .DataIn_DA   (DataIn_DA),
        .FifoFull_DA (FifoFull_DA),
        .Busy_DA     (Busy_DA)
    );

    initial clk_DA = 1'b0;
    always #5 clk_DA = ~clk_DA;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [DW-1:0] data;
    } expT;

    expT expQ[$];
    int  checks   = 0;
    int  failures = 0;
    int  pushCnt  = 0;
    int  seqCnt [NR];
    bit  autoMode = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectWord(input int idx, input logic [DW-1:0] data);
        expT e;
        e.ack  = NR'(1) << idx;
        e.data = data;
        expQ.push_back(e);
    endtask

    function automatic logic [DW-1:0] fixedWord(input int idx);
        return 32'hA000_0000 + 32'(idx);
    endfunction

    function automatic logic [DW-1:0] tagWord(input int idx, input int seq);
        return {16'(idx), 16'(seq)};
    endfunction

    // Requester word/Last drive: fixed words, or tagged packets in auto mode.
    task automatic setData();
        for (int i = 0; i < NR; i++) begin
            if (autoMode) begin
                Data_DA[i*DW +: DW] = tagWord(i, seqCnt[i]);
                Last_DA[i]          = (seqCnt[i] == 4);
            end else begin
                Data_DA[i*DW +: DW] = fixedWord(i);
            end
        end
    endtask

    // Per-cycle invariants and scoreboard pop for each push the FIFO takes.
    task automatic monitor();
        expT e;
        if (Grant_DA == '0) pushCnt = 0;
        chk("grant_onehot0", 64'($onehot0(Grant_DA)), 64'(1));
        if (Push_DA === 1'b1) begin
            pushCnt++;
            chk("push_while_full", 64'(FifoFull_DA), 64'(0));
            chk("ack_eq_grant", 64'(Ack_DA), 64'(Grant_DA));
            chk("ack_onehot", 64'($onehot(Ack_DA)), 64'(1));
            chk("burst_le_max", 64'(pushCnt <= int'(MB)), 64'(1));
            checks++;
            assert (expQ.size() > 0) else begin
                failures++;
                $error("FAIL sb_unexpected_push observed=%0h expected=none", DataIn_DA);
            end
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("sb_ack", 64'(Ack_DA), 64'(e.ack));
                chk("sb_data", 64'(DataIn_DA), 64'(e.data));
            end
        end else begin
            chk("ack_without_push", 64'(Ack_DA), 64'(0));
        end
    endtask

    // Close the current cycle: check, clock, and update requester models.
    task automatic adv();
        logic [NR-1:0] a;
        monitor();
        a = Ack_DA;
        @(posedge clk_DA);
        #1;
        if (autoMode) begin
            for (int i = 0; i < NR; i++) begin
                if (a[i]) begin
                    seqCnt[i]++;
                    if (seqCnt[i] == 5) Req_DA[i] = 1'b0;
                end
            end
            setData();
        end
    endtask

    task automatic cycleChk(input string tag, input logic [NR-1:0] expG, input logic expP);
        chk({tag, "_grant"}, 64'(Grant_DA), 64'(expG));
        chk({tag, "_push"},  64'(Push_DA),  64'(expP));
        chk({tag, "_busy"},  64'(Busy_DA),  64'(expG != '0));
    endtask

    initial begin
        logic [NR-1:0] eg;
        logic          ep;
        rst_n       = 1'b0;
        Req_DA      = '0;
        Last_DA     = '0;
        FifoFull_DA = 1'b0;
        Data_DA     = '0;
        for (int i = 0; i < NR; i++) seqCnt[i] = 0;
        setData();
        repeat (2) @(posedge clk_DA);
        #1;
        chk("rst_grant", 64'(Grant_DA), 64'(0));
        chk("rst_busy", 64'(Busy_DA), 64'(0));
        chk("rst_push", 64'(Push_DA), 64'(0));
        chk("rst_ack", 64'(Ack_DA), 64'(0));
        chk("rst_datain", 64'(DataIn_DA), 64'(fixedWord(0)));
        chk("rst_datain_known", 64'($isunknown(DataIn_DA)), 64'(0));
        rst_n = 1'b1;

        // Two requesters, MaxBurst-limited bursts.
        for (int k = 0; k < 8; k++) expectWord(0, fixedWord(0));
        for (int k = 0; k < 8; k++) expectWord(2, fixedWord(2));
        Req_DA = 4'b0101;
        for (int c = 0; c <= 18; c++) begin
            if (c == 18) Req_DA = '0;
            #1;
            eg = (c >= 1 && c <= 8) ? 4'b0001 : (c >= 10 && c <= 17) ? 4'b0100 : 4'b0000;
            cycleChk("maxburst", eg, eg != '0);
            adv();
        end

        // Requester 1 stalled by FIFO full for 5 cycles mid-burst.
        for (int k = 0; k < 8; k++) expectWord(1, fixedWord(1));
        for (int c = 0; c <= 14; c++) begin
            Req_DA      = (c < 14) ? 4'b0010 : 4'b0000;
            FifoFull_DA = (c >= 4 && c <= 8);
            #1;
            eg = (c >= 1 && c <= 13) ? 4'b0010 : 4'b0000;
            ep = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
            cycleChk("full", eg, ep);
            chk("full_ack", 64'(Ack_DA), 64'(ep ? 4'b0010 : 4'b0000));
            adv();
        end
        FifoFull_DA = 1'b0;

        // Requester 3 withdraws after 2 words; next winner must be 0.
        for (int k = 0; k < 2; k++) expectWord(3, fixedWord(3));
        for (int c = 0; c <= 6; c++) begin
            Req_DA = (c <= 2) ? 4'b1000 : (c <= 4) ? 4'b0111 : 4'b0000;
            #1;
            eg = (c >= 1 && c <= 3) ? 4'b1000 : (c == 5) ? 4'b0001 : 4'b0000;
            ep = (c == 1 || c == 2);
            cycleChk("drop", eg, ep);
            adv();
        end

        // Reset asserted while the third word is presented.
        for (int k = 0; k < 2; k++) expectWord(1, fixedWord(1));
        Req_DA = 4'b0010;
        for (int c = 0; c <= 2; c++) begin
            #1;
            eg = (c >= 1) ? 4'b0010 : 4'b0000;
            cycleChk("prerst", eg, eg != '0);
            adv();
        end
        #1;
        chk("rst3_push_before", 64'(Push_DA), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("rst3_push_async", 64'(Push_DA), 64'(0));
        chk("rst3_ack_async", 64'(Ack_DA), 64'(0));
        chk("rst3_grant", 64'(Grant_DA), 64'(0));
        chk("rst3_busy", 64'(Busy_DA), 64'(0));
        adv();
        adv();
        rst_n = 1'b1;

        // All requesting with Last on every word: single-word round robin.
        for (int k = 0; k < 5; k++) expectWord(k % 4, fixedWord(k % 4));
        Req_DA  = 4'b1111;
        Last_DA = 4'b1111;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) Req_DA = '0;
            #1;
            eg = (c % 2 == 1) ? (NR'(1) << (((c - 1) / 2) % 4)) : 4'b0000;
            cycleChk("rr", eg, eg != '0);
            adv();
        end
        Last_DA = '0;

        // Tagged 5-word packets from every requester, expected in RR order.
        for (int p = 0; p < 4; p++) begin
            for (int s = 0; s < 5; s++) expectWord((p + 1) % 4, tagWord((p + 1) % 4, s));
        end
        autoMode = 1'b1;
        Req_DA   = 4'b1111;
        setData();
        for (int c = 0; c < 60; c++) begin
            #1;
            adv();
            if (Req_DA == '0 && !Busy_DA) break;
        end
        chk("pkt_all_done", 64'(Req_DA), 64'(0));
        chk("pkt_idle", 64'(Busy_DA), 64'(0));
        for (int i = 0; i < NR; i++) chk("pkt_seq", 64'(seqCnt[i]), 64'(5));
        chk("sb_drained", 64'(expQ.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
